// File: rtl/flash_sample_streamer_if.sv
`timescale 1ns/1ps
// flash_sample_streamer_if
//   Sample stream carried from the flash streamer to its consumer.
//   data  : one sample, byte k at data[8k+:8]
//   valid : data holds a sample that has not been transferred yet
//   ready : consumer accepts data; a transfer happens on any edge with valid && ready
//   Modports: master (streamer side), slave (consumer side).
interface flash_sample_streamer_if #(
  parameter int unsigned BYTES_PER_SAMPLE = 2
) ();

  localparam int unsigned DATA_W = 8 * BYTES_PER_SAMPLE;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/flash_sample_streamer.sv
`timescale 1ns/1ps
// flash_sample_streamer
//   Streams NUM_SAMPLES little-endian samples of BYTES_PER_SAMPLE bytes, read
//   byte by byte from the DE2 8-bit parallel flash starting at BASE_ADDR, onto
//   a valid/ready stream. One finished sample can wait in a holding register
//   while the output slot is still occupied, so the next flash fetch overlaps
//   consumer back-pressure.
//
//   Parameters
//     BYTES_PER_SAMPLE : 1..4, sample width = 8*BYTES_PER_SAMPLE
//     NUM_SAMPLES      : >= 1, samples per run
//     BASE_ADDR        : flash byte address of sample 0, byte 0
//     WAIT_CYCLES      : 1..15, cycles the flash is held selected before a byte is captured
//
//   Ports
//     CLOCK_50  : clock (50 MHz)
//     resetb    : asynchronous active-low reset
//     start     : begin a run; only looked at while idle or done
//     FL_ADDR   : flash byte address
//     FL_CE_N   : flash chip enable, active low
//     FL_OE_N   : flash output enable, active low
//     FL_WE_N   : constant 1 (never writes)
//     FL_RST_N  : constant 1
//     FL_DQ     : flash data in
//     strm      : sample stream, master side (data / valid / ready)
//     busy      : run in progress
//     done      : all samples transferred; sticky until the next start
//
//   Build option
//     FLASH_STREAM_LOOP_EN : when defined the sample index wraps after the last
//                            sample and streaming never ends (done stays 0).
module flash_sample_streamer #(
  parameter int unsigned BYTES_PER_SAMPLE = 2,
  parameter int unsigned NUM_SAMPLES      = 256,
  parameter logic [21:0] BASE_ADDR        = 22'd0,
  parameter int unsigned WAIT_CYCLES      = 6
) (
  input  logic                           CLOCK_50,
  input  logic                           resetb,
  input  logic                           start,
  output logic [21:0]                    FL_ADDR,
  output logic                           FL_CE_N,
  output logic                           FL_OE_N,
  output logic                           FL_WE_N,
  output logic                           FL_RST_N,
  input  logic [7:0]                     FL_DQ,
  flash_sample_streamer_if.master        strm,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned DATA_W = 8 * BYTES_PER_SAMPLE;
  localparam int unsigned IDX_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int unsigned K_W    = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
  localparam int unsigned WCNT_W = 4;
  localparam int unsigned ADDR_W = 22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_PUSH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  // Set once the final sample sits in the output slot; PUSH then only waits
  // for that last transfer.
  logic                last_q, last_d;

  logic                xfer_c;
  logic [ADDR_W-1:0]   byte_addr_c;

  // Transfer on this edge.
  assign xfer_c = valid_q && strm.ready;

  // Byte address of the current byte, wrapping modulo 2^22.
  assign byte_addr_c = ADDR_W'(BASE_ADDR
                              + ADDR_W'(idx_q) * ADDR_W'(BYTES_PER_SAMPLE)
                              + ADDR_W'(k_q));

  // State register and all registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      k_q     <= '0;
      wcnt_q  <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    idx_d   = idx_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    last_d  = last_q;

    // A transfer empties the slot in any state; PUSH may refill it below.
    if (xfer_c) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          k_d     = '0;
          last_d  = 1'b0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        addr_d  = byte_addr_c;
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end

      // Address, CE and OE held while the flash access time elapses.
      S_WAIT: begin
        if (wcnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
          state_d = S_LOAD;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      S_LOAD: begin
        for (int unsigned b = 0; b < BYTES_PER_SAMPLE; b++) begin
          if (k_q == K_W'(b)) begin
            hold_d[8*b +: 8] = FL_DQ;
          end
        end
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        if (k_q == K_W'(BYTES_PER_SAMPLE - 1)) begin
          k_d     = '0;
          state_d = S_PUSH;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_READ;
        end
      end

      S_PUSH: begin
        if (last_q) begin
          // Drain: the final sample is in the slot, finish on its transfer.
          if (xfer_c) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            last_d  = 1'b0;
            state_d = S_DONE;
          end
        end else if (!valid_q || xfer_c) begin
          data_d  = hold_q;
          valid_d = 1'b1;
          if (idx_q < IDX_W'(NUM_SAMPLES - 1)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_READ;
          end else begin
`ifdef FLASH_STREAM_LOOP_EN
            idx_d   = '0;
            state_d = S_READ;
`else
            last_d  = 1'b1;
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign FL_ADDR    = addr_q;
  assign FL_CE_N    = ce_n_q;
  assign FL_OE_N    = oe_n_q;
  assign FL_WE_N    = 1'b1;
  assign FL_RST_N   = 1'b1;
  assign strm.data  = data_q;
  assign strm.valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
`timescale 1ns/1ps
// Bench for flash_sample_streamer: two instances (default geometry and a
// 3-byte, 4-sample one whose addresses wrap at the top of flash), each with a
// flash model returning address[7:0] while selected.
module tb_flash_sample_streamer;

  localparam int unsigned BPS0  = 2;
  localparam int unsigned N0    = 256;
  localparam int unsigned BASE0 = 32'h0;
  localparam int unsigned W0    = 6;

  localparam int unsigned BPS1  = 3;
  localparam int unsigned N1    = 4;
  localparam int unsigned BASE1 = 32'h3FFFFE;
  localparam int unsigned W1    = 3;

  logic        CLOCK_50 = 1'b0;
  logic        resetb   = 1'b1;
  logic        start0, start1;
  logic [21:0] FL_ADDR0, FL_ADDR1;
  logic        FL_CE_N0, FL_OE_N0, FL_WE_N0, FL_RST_N0;
  logic        FL_CE_N1, FL_OE_N1, FL_WE_N1, FL_RST_N1;
  logic [7:0]  FL_DQ0, FL_DQ1;
  logic        busy0, done0, busy1, done1;

  flash_sample_streamer_if #(.BYTES_PER_SAMPLE(BPS0)) s0 ();
  flash_sample_streamer_if #(.BYTES_PER_SAMPLE(BPS1)) s1 ();

  always #10 CLOCK_50 = ~CLOCK_50;

  // Flash model: byte value equals low address byte while selected.
  assign FL_DQ0 = (!FL_CE_N0 && !FL_OE_N0) ? FL_ADDR0[7:0] : 8'hA5;
  assign FL_DQ1 = (!FL_CE_N1 && !FL_OE_N1) ? FL_ADDR1[7:0] : 8'hA5;

  flash_sample_streamer #(
    .BYTES_PER_SAMPLE(BPS0), .NUM_SAMPLES(N0), .BASE_ADDR(22'(BASE0)), .WAIT_CYCLES(W0)
  ) dut0 (
    .CLOCK_50(CLOCK_50), .resetb(resetb), .start(start0),
    .FL_ADDR(FL_ADDR0), .FL_CE_N(FL_CE_N0), .FL_OE_N(FL_OE_N0),
    .FL_WE_N(FL_WE_N0), .FL_RST_N(FL_RST_N0), .FL_DQ(FL_DQ0),
    .strm(s0), .busy(busy0), .done(done0)
  );

  flash_sample_streamer #(
    .BYTES_PER_SAMPLE(BPS1), .NUM_SAMPLES(N1), .BASE_ADDR(22'(BASE1)), .WAIT_CYCLES(W1)
  ) dut1 (
    .CLOCK_50(CLOCK_50), .resetb(resetb), .start(start1),
    .FL_ADDR(FL_ADDR1), .FL_CE_N(FL_CE_N1), .FL_OE_N(FL_OE_N1),
    .FL_WE_N(FL_WE_N1), .FL_RST_N(FL_RST_N1), .FL_DQ(FL_DQ1),
    .strm(s1), .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;
  int n0, n1;       // transfers seen since the last start
  int nf0, nf1;     // flash byte fetches (CE falling) since the last start
  int low0, fall0;  // CE-low cycles / fetches in a measurement window
  logic pce0, pce1;

  // Expected sample n: little-endian bytes from base + (n mod nsmp)*bps, modulo 2^22.
  function automatic logic [31:0] exp_sample(input int unsigned base, input int unsigned bps,
                                             input int unsigned nsmp, input int unsigned n);
    logic [31:0] s;
    logic [21:0] a;
    s = '0;
    for (int unsigned j = 0; j < bps; j++) begin
      a = 22'(base + (n % nsmp) * bps + j);
      s[8*j +: 8] = a[7:0];
    end
    return s;
  endfunction

  // Expected address of the f-th byte fetch.
  function automatic logic [31:0] exp_addr(input int unsigned base, input int unsigned bps,
                                           input int unsigned nsmp, input int unsigned f);
    logic [21:0] a;
    a = 22'(base + (f % (nsmp * bps)));
    return 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: score transfers and fetch addresses, then move to the next negedge.
  task automatic tick();
    if (s0.valid === 1'b1 && s0.ready === 1'b1) begin
      chk("data0", 32'(s0.data), exp_sample(BASE0, BPS0, N0, n0));
      n0++;
    end
    if (s1.valid === 1'b1 && s1.ready === 1'b1) begin
      chk("data1", 32'(s1.data), exp_sample(BASE1, BPS1, N1, n1));
      n1++;
    end
    if (FL_CE_N0 === 1'b0 && pce0 === 1'b1) begin
      chk("addr0", 32'(FL_ADDR0), exp_addr(BASE0, BPS0, N0, nf0));
      nf0++;
      fall0++;
    end
    if (FL_CE_N1 === 1'b0 && pce1 === 1'b1) begin
      chk("addr1", 32'(FL_ADDR1), exp_addr(BASE1, BPS1, N1, nf1));
      nf1++;
    end
    if (FL_CE_N0 === 1'b0) low0++;
    pce0 = FL_CE_N0;
    pce1 = FL_CE_N1;
    @(negedge CLOCK_50);
  endtask

  initial begin
    int lat;
    int cyc;
    start0 = 1'b0; start1 = 1'b0;
    s0.ready = 1'b0; s1.ready = 1'b0;
    n0 = 0; n1 = 0; nf0 = 0; nf1 = 0; low0 = 0; fall0 = 0;
    pce0 = 1'b1; pce1 = 1'b1;
    resetb = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // Reset state of both instances.
    chk("rst_ce0",    32'(FL_CE_N0), 32'd1);
    chk("rst_oe0",    32'(FL_OE_N0), 32'd1);
    chk("rst_addr0",  32'(FL_ADDR0), 32'd0);
    chk("rst_data0",  32'(s0.data),  32'd0);
    chk("rst_valid0", 32'(s0.valid), 32'd0);
    chk("rst_busy0",  32'(busy0),    32'd0);
    chk("rst_done0",  32'(done0),    32'd0);
    chk("rst_we0",    32'(FL_WE_N0), 32'd1);
    chk("rst_frst0",  32'(FL_RST_N0), 32'd1);
    chk("rst_data1",  32'(s1.data),  32'd0);
    chk("rst_valid1", 32'(s1.valid), 32'd0);
    chk("rst_ce1",    32'(FL_CE_N1), 32'd1);
    resetb = 1'b1;
    @(negedge CLOCK_50);

    // Instance 1: 3-byte samples wrapping past the top of flash.
    s1.ready = 1'b1; n1 = 0; nf1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("busy1_start", 32'(busy1), 32'd1);
    lat = 0;
    while (s1.valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("lat1",   32'(lat),     32'd16);
    chk("first1", 32'(s1.data), 32'h00FFFE);
    cyc = 0;
`ifndef FLASH_STREAM_LOOP_EN
    while (done1 !== 1'b1 && cyc < 3000) begin
      s1.ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("done1",  32'(done1),    32'd1);
    chk("n1",     32'(n1),       32'd4);
    chk("nf1",    32'(nf1),      32'd12);
    chk("busy1",  32'(busy1),    32'd0);
    chk("valid1", 32'(s1.valid), 32'd0);
`else
    while (n1 < 10 && cyc < 3000) begin
      s1.ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("loop_n1",    32'(n1),    32'd10);
    chk("loop_done1", 32'(done1), 32'd0);
    chk("loop_busy1", 32'(busy1), 32'd1);
`endif
    s1.ready = 1'b0;

    // Instance 0: latency and first sample.
    s0.ready = 1'b1; n0 = 0; nf0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 0;
    while (s0.valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("lat0",   32'(lat),     32'd17);
    chk("first0", 32'(s0.data), 32'h0100);

    // Back-pressure: data held, exactly one sample prefetched.
    s0.ready = 1'b0; low0 = 0; fall0 = 0;
    repeat (100) begin
      tick();
      chk("stall_data0",  32'(s0.data),  32'h0100);
      chk("stall_valid0", 32'(s0.valid), 32'd1);
    end
    chk("stall_fetches0", 32'(fall0),    32'd2);
    chk("stall_celow0",   32'(low0),     32'(2 * (W0 + 1)));
    chk("stall_ce0",      32'(FL_CE_N0), 32'd1);
    s0.ready = 1'b1;
    tick();
    chk("next_data0",  32'(s0.data),  32'h0302);
    chk("next_valid0", 32'(s0.valid), 32'd1);

    // Random back-pressure for the rest of the run; start held high early on.
    cyc = 0;
    start0 = 1'b1;
`ifndef FLASH_STREAM_LOOP_EN
    while (done0 !== 1'b1 && cyc < 30000) begin
      if (cyc == 500) start0 = 1'b0;
      s0.ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    start0 = 1'b0;
    chk("done0",  32'(done0),    32'd1);
    chk("n0",     32'(n0),       32'd256);
    chk("nf0",    32'(nf0),      32'd512);
    chk("busy0",  32'(busy0),    32'd0);
    chk("valid0", 32'(s0.valid), 32'd0);
    repeat (10) begin
      s0.ready = 1'b1;
      tick();
      chk("done_ce0",   32'(FL_CE_N0), 32'd1);
      chk("done_held0", 32'(done0),    32'd1);
    end
`else
    while (n0 < 600 && cyc < 30000) begin
      if (cyc == 500) start0 = 1'b0;
      s0.ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    start0 = 1'b0;
    chk("loop_n0",    32'(n0),    32'd600);
    chk("loop_done0", 32'(done0), 32'd0);
    chk("loop_busy0", 32'(busy0), 32'd1);
    resetb = 1'b0;
    @(negedge CLOCK_50);
    resetb = 1'b1;
    pce0 = FL_CE_N0;
    @(negedge CLOCK_50);
`endif

    // New run from a finished (or freshly reset) state.
    s0.ready = 1'b1; n0 = 0; nf0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("rerun_done0", 32'(done0), 32'd0);
    chk("rerun_busy0", 32'(busy0), 32'd1);
    cyc = 0;
    while (n0 < 4 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("reach_n4", 32'(n0), 32'd4);
    s0.ready = 1'b0;
    cyc = 0;
    while (!(FL_CE_N0 === 1'b0 && FL_ADDR0 === 22'd10) && cyc < 1000) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    chk("wait5_ce0",    32'(FL_CE_N0), 32'd0);
    chk("wait5_valid0", 32'(s0.valid), 32'd1);
    chk("wait5_data0",  32'(s0.data),  exp_sample(BASE0, BPS0, N0, 4));

    // Asynchronous reset in the middle of a clock period.
    #3 resetb = 1'b0;
    #1;
    chk("arst_ce0",    32'(FL_CE_N0), 32'd1);
    chk("arst_oe0",    32'(FL_OE_N0), 32'd1);
    chk("arst_valid0", 32'(s0.valid), 32'd0);
    chk("arst_busy0",  32'(busy0),    32'd0);
    chk("arst_addr0",  32'(FL_ADDR0), 32'd0);
    chk("arst_data0",  32'(s0.data),  32'd0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetb = 1'b1;
    pce0 = FL_CE_N0;
    @(negedge CLOCK_50);

    // Restart after reset begins again at BASE_ADDR.
    s0.ready = 1'b1; n0 = 0; nf0 = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0;
    while (n0 < 3 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("restart_n0", 32'(n0), 32'd3);
    chk("restart_nf0_min", 32'(nf0 >= 6), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_sample_streamer.md
Name: flash_sample_streamer

Overview:
- Parametrised streaming reader for the DE2 parallel flash (8-bit data bus).
- Fetches NUM_SAMPLES little-endian samples of BYTES_PER_SAMPLE bytes from BASE_ADDR onward.
- Presents samples on a valid/ready interface. A one-sample prefetch lets the next flash fetch overlap consumer back-pressure.
- Sits between the flash pins and audio/sample consumers; supersedes the fixed 16-bit, 256-sample, next-pulse reader.

Parameters:
- BYTES_PER_SAMPLE, 2: bytes per sample; data width = 8*BYTES_PER_SAMPLE; legal range 1-4.
- NUM_SAMPLES, 256: samples per run; must be at least 1; index width = $clog2(NUM_SAMPLES), minimum 1.
- BASE_ADDR, 22'd0: flash byte address of sample 0, byte 0.
- WAIT_CYCLES, 6: clock cycles held in WAIT per byte; 6 at 50 MHz covers the 110 ns access time; legal range 1-15.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- resetb  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled in IDLE or DONE only
- FL_ADDR  output  22  flash byte address
- FL_CE_N  output  1  flash chip enable, active low
- FL_OE_N  output  1  flash output enable, active low
- FL_WE_N  output  1  tied 1
- FL_RST_N  output  1  tied 1
- FL_DQ  input  8  flash data; top level keeps the pad inout, undriven
- data  output  8*BYTES_PER_SAMPLE  sample; byte k at data[8k+:8]
- valid  output  1  data holds an untransferred sample
- ready  input  1  consumer accepts data
- busy  output  1  run in progress
- done  output  1  all NUM_SAMPLES transferred; sticky

Behaviour:
- Reset (asynchronous; takes effect immediately, including mid-fetch or mid-handshake):
  - FL_CE_N=1, FL_OE_N=1, FL_ADDR=0
  - data=0, valid=0, busy=0, done=0
  - sample index=0, byte index=0; state=IDLE
  - FL_WE_N and FL_RST_N are constant 1.
- States: IDLE, READ, WAIT, LOAD, PUSH, DONE.
- IDLE / DONE, start=1:
  - done<=0, busy<=1, index<=0, go to READ.
  - start is ignored in all other states.
- READ (1 cycle):
  - FL_ADDR <= BASE_ADDR + idx*BYTES_PER_SAMPLE + k, truncated modulo 2^22.
  - FL_CE_N<=0, FL_OE_N<=0; go to WAIT.
- WAIT:
  - Counter runs 0..WAIT_CYCLES-1, then goes to LOAD. Address, CE and OE are held stable.
- LOAD (1 cycle):
  - hold[8k+:8] <= FL_DQ; FL_CE_N<=1, FL_OE_N<=1.
  - If k < BYTES_PER_SAMPLE-1: k++, go to READ. Otherwise k<=0, go to PUSH.
- Per byte: WAIT_CYCLES+2 cycles.
- PUSH: the output slot is free when valid=0 or (valid && ready) this cycle.
  - Slot free: data<=hold, valid<=1.
    - If idx < NUM_SAMPLES-1: idx++, go to READ (prefetch).
    - Otherwise go to DRAIN behaviour: stay in PUSH with nothing pending until the final transfer.
  - Slot not free: stall in PUSH; flash stays deselected.
- Handshake:
  - A transfer occurs on any edge with valid && ready.
  - data is stable while valid=1 and not transferred.
  - valid falls after a transfer unless a new sample loads on the same edge.
  - ready while valid=0 has no effect.
- Completion:
  - After the final sample's transfer edge: valid<=0, busy<=0, done<=1, state=DONE.
  - done is not asserted on fetch alone.
- Latency: start edge to valid high = BYTES_PER_SAMPLE*(WAIT_CYCLES+2)+1 cycles; 17 with defaults.
- Sustained throughput with ready held at 1: one sample per BYTES_PER_SAMPLE*(WAIT_CYCLES+2)+1 cycles.
- NUM_SAMPLES=1: exactly one fetch, one transfer, then DONE.

Optional Feature:
- Macro: FLASH_STREAM_LOOP_EN.
- Defined:
  - After the last sample loads into data, idx wraps to 0 and prefetch continues.
  - done never asserts; busy stays 1 until reset.
  - Address sequence repeats BASE_ADDR...
- Undefined: single run as above; the wrap logic is absent.

Test Plan:
- Defaults, flash model returns byte = address[7:0], ready=1, pulse start:
  - First valid 17 cycles after start with data=16'h0100; second sample 16'h0302.
  - done=1 after 256 transfers; FL_CE_N high throughout DONE.
- ready=0 for 100 cycles after the first valid:
  - data stays 16'h0100 and valid stays 1.
  - Exactly one prefetch occurs (FL_CE_N low for 2 bytes), then CE stays high.
  - On ready=1, sample 16'h0302 appears on the edge after transfer (PUSH has it pending).
- BYTES_PER_SAMPLE=3, NUM_SAMPLES=4, BASE_ADDR=22'h3FFFFE:
  - FL_ADDR sequence wraps 3FFFFE, 3FFFFF, 000000, ...
  - data[23:0] = {00,FF,FE} for sample 0; done after 4 transfers.
- Reset asserted during WAIT of sample 5:
  - FL_CE_N, FL_OE_N go 1 and valid goes 0 immediately, without waiting for a clock edge.
  - After release and a new start, FL_ADDR restarts at BASE_ADDR.
- start held high during a run: no restart, idx monotonic; start in DONE clears done and reruns from sample 0.
- FLASH_STREAM_LOOP_EN, NUM_SAMPLES=2: transfers yield samples 0,1,0,1,...; done stays 0; busy stays 1.
